inst_prefetcher: RTL

Parametrised instruction prefetch unit that supersedes the single-word fetch path of the core. It keeps up to DEPTH fetched instructions in flight ahead of the executor, and drives the instruction-memory valid/ready port autonomously. It discards stale words on a redirect (taken branch/jump) and delivers instructions with their PCs to the controller over a valid/ready handshake.

---
 rtl/prefetch_pkg.sv | 16 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/inst_prefetcher.sv | 129 ++++++++++++
 3 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// No logic; pure declarations.
// No handshakes; consumed by the prefetcher top.
package prefetch_pkg;

  // Fetch FSM: no request, live request, or request whose data is stale
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } prefetch_state_t;

  // Byte distance between consecutive instruction words
  localparam int INST_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with wrap-around pointers, occupancy count and flush.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push when full is accepted only alongside a pop; flush wins.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is zeroed at reset so the head reads 0 until the first push
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/inst_prefetcher.sv
// Instruction prefetcher: keeps up to DEPTH words in flight ahead of the core.
// Latency: fetched word at queue head one cycle after memory ready; next addr one cycle after ready.
// Backpressure: issue stalls while the queue is full; redirect flushes and drains any stale request.
module inst_prefetcher
  import prefetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          inst_mem_out_addr,
  output logic                       inst_mem_out_valid,
  input  logic [DATA_W-1:0]          inst_mem_out_data,
  input  logic                       inst_mem_out_ready,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  output logic [DATA_W-1:0]          inst_data,
  output logic [ADDR_W-1:0]          inst_pc,
  input  logic                       inst_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);

  prefetch_state_t            state;
  logic                       req_vld;
  logic [ADDR_W-1:0]          fetch_pc;
  logic [ADDR_W-1:0]          pend_pc;
  logic [ADDR_W-1:0]          redirect_aligned;
  logic                       mem_done;
  logic                       do_push;
  logic                       do_pop;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       has_room;
  logic [CNT_W-1:0]           occ_next;
  logic [ADDR_W+DATA_W-1:0]   head_dat;

  assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign mem_done         = req_vld && inst_mem_out_ready;
  // Redirect owns the queue that cycle: no push, no pop, just clear
  assign do_push          = (state == REQ) && inst_mem_out_ready && !redirect_valid;
  assign do_pop           = inst_valid && inst_ready && !redirect_valid;

  // Occupancy after this cycle's push/pop decides whether to keep fetching
  always_comb begin
    occ_next = occupancy;
    if (do_push && !do_pop)      occ_next = occupancy + 1'b1;
    else if (!do_push && do_pop) occ_next = occupancy - 1'b1;
  end

  assign has_room = (occ_next < DEPTH_C);

  // Fetch FSM with registered request valid; address only moves on ready or while idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      req_vld  <= 1'b0;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      if (state == IDLE || mem_done) begin
        state    <= REQ;
        req_vld  <= 1'b1;
        fetch_pc <= redirect_aligned;
      end else begin
        state   <= DROP;
        pend_pc <= redirect_aligned;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_full || do_pop) begin
            state   <= REQ;
            req_vld <= 1'b1;
          end
        end
        REQ: begin
          if (inst_mem_out_ready) begin
            fetch_pc <= fetch_pc + STEP;
            state    <= has_room ? REQ : IDLE;
            req_vld  <= has_room;
          end
        end
        DROP: begin
          if (inst_mem_out_ready) begin
            fetch_pc <= pend_pc;
            state    <= has_room ? REQ : IDLE;
            req_vld  <= has_room;
          end
        end
        default: begin
          state   <= IDLE;
          req_vld <= 1'b0;
        end
      endcase
    end
  end

  assign inst_mem_out_addr  = fetch_pc;
  assign inst_mem_out_valid = req_vld;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (do_push),
    .push_dat ({fetch_pc, inst_mem_out_data}),
    .pop      (do_pop),
    .head_dat (head_dat),
    .flush    (redirect_valid),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy)
  );

  assign inst_valid = !fifo_empty;
  assign inst_pc    = head_dat[ADDR_W+DATA_W-1:DATA_W];
  assign inst_data  = head_dat[DATA_W-1:0];

endmodule
